// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU data path and its program loader:
// opcodes, instruction memory geometry, loader states and error codes.
package cpu_pkg;

    localparam int IMEM_DEPTH  = 16;
    localparam int IMEM_ADDR_W = 4;

    localparam logic [3:0] OPC_LOAD = 4'h1;
    localparam logic [3:0] OPC_ADD  = 4'h2;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN  = 3'd1,
        LD_DATA = 3'd2,
        LD_CHK  = 3'd3,
        LD_DONE = 3'd4,
        LD_ERR  = 3'd5
    } ld_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // Frame checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/inst_mem_2p.sv
// Instruction memory: one synchronous write port and one registered read port.
// A read and write to the same address in one cycle return the old contents.
module inst_mem_2p
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; a disabled read returns zero so the caller can mask by length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= {DATA_W{1'b0}};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader (length, bytes, checksum) feeding the
// instruction memory, plus the length-masked CPU fetch port.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_data,
    output logic [4:0]        prog_len,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_err,
    output logic [1:0]        err_code
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       DEPTH_B  = 8'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    ld_state_e         state_q, state_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [TMO_W-1:0]  idle_q, idle_d;
    logic [1:0]        err_q, err_d;
    logic [4:0]        plen_q, plen_d;
    logic              busy_q, busy_d;
    logic              run_q, run_d;
    logic              lerr_q, lerr_d;
    logic              xfer_s;
    logic              we_s;
    logic              re_s;

    assign s_ready = busy_q && !load_start;
    assign xfer_s  = s_valid && s_ready;

    // State and bookkeeping registers, including the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            len_q   <= {IDX_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            sum_q   <= 8'h00;
            idle_q  <= {TMO_W{1'b0}};
            err_q   <= ERR_NONE;
            plen_q  <= 5'd0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            plen_q  <= plen_d;
            busy_q  <= busy_d;
            run_q   <= run_d;
            lerr_q  <= lerr_d;
        end
    end

    // Next-state logic; load_start overrides everything else.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        idle_d  = idle_q;
        err_d   = err_q;
        plen_d  = plen_q;
        we_s    = 1'b0;
        if (load_start) begin
            state_d = LD_LEN;
            len_d   = {IDX_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
            sum_d   = 8'h00;
            idle_d  = {TMO_W{1'b0}};
            err_d   = ERR_NONE;
            plen_d  = 5'd0;
        end else begin
            case (state_q)
                LD_LEN: begin
                    if (!xfer_s) begin
                        state_d = LD_LEN;
                    end else if ((s_data == 8'h00) || (s_data > DEPTH_B)) begin
                        state_d = LD_ERR;
                        err_d   = ERR_LEN;
                    end else begin
                        len_d   = s_data[IDX_W-1:0];
                        idle_d  = {TMO_W{1'b0}};
                        state_d = LD_DATA;
                    end
                end
                LD_DATA, LD_CHK: begin
                    if (xfer_s) begin
                        idle_d = {TMO_W{1'b0}};
                        if (state_q == LD_DATA) begin
                            we_s  = 1'b1;
                            sum_d = csum_add(sum_q, s_data);
                            idx_d = idx_q + IDX_ONE;
                            if ((idx_q + IDX_ONE) == len_q) begin
                                state_d = LD_CHK;
                            end else begin
                                state_d = LD_DATA;
                            end
                        end else if (s_data == sum_q) begin
                            state_d = LD_DONE;
                            plen_d  = 5'(len_q);
                        end else begin
                            state_d = LD_ERR;
                            err_d   = ERR_CHK;
                        end
                    end else if (idle_q == TMO_LAST) begin
                        // This is the TIMEOUT-th consecutive idle cycle.
                        state_d = LD_ERR;
                        err_d   = ERR_TMO;
                        idle_d  = {TMO_W{1'b0}};
                    end else begin
                        idle_d = idle_q + TMO_ONE;
                    end
                end
                LD_IDLE, LD_DONE, LD_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = LD_IDLE;
                    plen_d  = 5'd0;
                end
            endcase
        end
    end

    // Status outputs are registered copies of the next-state decode.
    always_comb begin
        busy_d = 1'b0;
        run_d  = 1'b0;
        lerr_d = 1'b0;
        case (state_d)
            LD_LEN, LD_DATA, LD_CHK: busy_d = 1'b1;
            LD_DONE:                 run_d  = 1'b1;
            LD_ERR:                  lerr_d = 1'b1;
            default:                 busy_d = 1'b0;
        endcase
    end

    assign re_s = {1'b0, fetch_addr} < plen_q;

    inst_mem_2p #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_imem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_s),
        .waddr_i (idx_q[ADDR_W-1:0]),
        .wdata_i (s_data),
        .re_i    (re_s),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

    assign prog_len = plen_q;
    assign cpu_run  = run_q;
    assign busy     = busy_q;
    assign load_err = lerr_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; each task covers one scenario.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic [4:0] prog_len;
    logic       cpu_run;
    logic       busy;
    logic       load_err;
    logic [1:0] err_code;

    logic       m_we;
    logic [3:0] m_waddr;
    logic [7:0] m_wdata;
    logic       m_re;
    logic [3:0] m_raddr;
    logic [7:0] m_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .prog_len   (prog_len),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    inst_mem_2p u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (m_we),
        .waddr_i (m_waddr),
        .wdata_i (m_wdata),
        .re_i    (m_re),
        .raddr_i (m_raddr),
        .rdata_o (m_rdata)
    );

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_byte: s_ready=%0b required 1 within 50 cycles", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic pulse_start(output logic rdy);
        load_start = 1'b1;
        @(negedge clk);
        rdy = s_ready;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic check_fetch(input logic [3:0] a, input logic [7:0] exp, input string nm);
        fetch_addr = a;
        @(posedge clk);
        #1;
        n_cmp++;
        if (fetch_data !== exp) begin
            n_mis++;
            $display("FAIL %s: fetch_data[%0d]=%02h required %02h", nm, a, fetch_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = 8'h00; fetch_addr = 4'd0;
        m_we = 1'b0; m_waddr = 4'd0; m_wdata = 8'h00; m_re = 1'b0; m_raddr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({s_ready, fetch_data, prog_len, cpu_run, busy, load_err, err_code} !== 19'd0) begin
            n_mis++;
            $display("FAIL reset: outputs=%0h required 0", {s_ready, fetch_data, prog_len, cpu_run, busy, load_err, err_code});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] f [0:5];
        logic rdy;
        f = '{8'h04, 8'h00, 8'h01, 8'h04, 8'h03, 8'h08};
        pulse_start(rdy);
        for (int i = 0; i < 6; i++) send_byte(f[i]);
        n_cmp++;
        if (cpu_run !== 1'b1 || prog_len !== 5'd4 || err_code !== 2'b00 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_done: run=%0b len=%0d err=%0d busy=%0b required 1 4 0 0", cpu_run, prog_len, err_code, busy);
        end
        check_fetch(4'd2, 8'h04, "basic_fetch2");
        check_fetch(4'd0, 8'h00, "basic_fetch0");
        check_fetch(4'd3, 8'h03, "basic_fetch3");
        check_fetch(4'd5, 8'h00, "basic_fetch5_masked");
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [0:1];
        logic rdy;
        lens = '{8'h00, 8'h11};
        for (int i = 0; i < 2; i++) begin
            pulse_start(rdy);
            send_byte(lens[i]);
            n_cmp++;
            if (load_err !== 1'b1 || err_code !== 2'b01 || s_ready !== 1'b0 || prog_len !== 5'd0 || cpu_run !== 1'b0) begin
                n_mis++;
                $display("FAIL bad_len_%02h: err=%0b code=%0d rdy=%0b len=%0d run=%0b required 1 1 0 0 0",
                         lens[i], load_err, err_code, s_ready, prog_len, cpu_run);
            end
        end
    endtask

    task automatic test_checksum();
        logic rdy;
        pulse_start(rdy);
        send_byte(8'h02); send_byte(8'h05); send_byte(8'h06); send_byte(8'h0C);
        n_cmp++;
        if (load_err !== 1'b1 || err_code !== 2'b10 || prog_len !== 5'd0) begin
            n_mis++;
            $display("FAIL chk_bad: err=%0b code=%0d len=%0d required 1 2 0", load_err, err_code, prog_len);
        end
        check_fetch(4'd0, 8'h00, "chk_bad_fetch_masked");
        pulse_start(rdy);
        n_cmp++;
        if (load_err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL chk_restart: err=%0b code=%0d busy=%0b required 0 0 1", load_err, err_code, busy);
        end
        send_byte(8'h02); send_byte(8'h05); send_byte(8'h06); send_byte(8'h0B);
        n_cmp++;
        if (cpu_run !== 1'b1 || prog_len !== 5'd2 || load_err !== 1'b0) begin
            n_mis++;
            $display("FAIL chk_good: run=%0b len=%0d err=%0b required 1 2 0", cpu_run, prog_len, load_err);
        end
        check_fetch(4'd1, 8'h06, "chk_good_fetch1");
    endtask

    task automatic test_timeout();
        logic rdy;
        pulse_start(rdy);
        send_byte(8'h04); send_byte(8'h10); send_byte(8'h20);
        repeat (254) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || load_err !== 1'b0) begin
            n_mis++;
            $display("FAIL tmo_254: busy=%0b err=%0b required 1 0", busy, load_err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || load_err !== 1'b1 || err_code !== 2'b11 || prog_len !== 5'd0) begin
            n_mis++;
            $display("FAIL tmo_255: busy=%0b err=%0b code=%0d len=%0d required 0 1 3 0", busy, load_err, err_code, prog_len);
        end
    endtask

    task automatic test_abort();
        logic rdy;
        pulse_start(rdy);
        send_byte(8'h04); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        s_valid = 1'b1;
        s_data  = 8'h02;
        pulse_start(rdy);
        s_valid = 1'b0;
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_ready: s_ready=%0b required 0 in load_start cycle", rdy);
        end
        n_cmp++;
        if (busy !== 1'b1 || prog_len !== 5'd0 || cpu_run !== 1'b0) begin
            n_mis++;
            $display("FAIL abort_state: busy=%0b len=%0d run=%0b required 1 0 0", busy, prog_len, cpu_run);
        end
        send_byte(8'h02); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h15);
        n_cmp++;
        if (cpu_run !== 1'b1 || prog_len !== 5'd2) begin
            n_mis++;
            $display("FAIL abort_reload: run=%0b len=%0d required 1 2", cpu_run, prog_len);
        end
        check_fetch(4'd0, 8'h0A, "abort_fetch0");
        check_fetch(4'd1, 8'h0B, "abort_fetch1");
        check_fetch(4'd2, 8'h00, "abort_fetch2_masked");
    endtask

    task automatic test_random_gaps();
        logic [7:0] img [0:15];
        logic [7:0] sum;
        logic rdy;
        sum = 8'h00;
        pulse_start(rdy);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            sum = sum + img[i];
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            send_byte(img[i]);
        end
        repeat ($urandom_range(0, 6)) @(posedge clk);
        #1;
        send_byte(sum);
        n_cmp++;
        if (cpu_run !== 1'b1 || prog_len !== 5'd16 || load_err !== 1'b0) begin
            n_mis++;
            $display("FAIL gaps_done: run=%0b len=%0d err=%0b required 1 16 0", cpu_run, prog_len, load_err);
        end
        for (int i = 0; i < 16; i++) check_fetch(4'(i), img[i], "gaps_fetch");
    endtask

    task automatic test_rbw();
        m_we = 1'b1; m_waddr = 4'd3; m_wdata = 8'hAA; m_re = 1'b0; m_raddr = 4'd3;
        @(posedge clk);
        #1;
        m_wdata = 8'h55; m_re = 1'b1;
        @(posedge clk);
        #1;
        m_we = 1'b0;
        n_cmp++;
        if (m_rdata !== 8'hAA) begin
            n_mis++;
            $display("FAIL rbw_old: rdata=%02h required AA", m_rdata);
        end
        @(posedge clk);
        #1;
        m_re = 1'b0;
        n_cmp++;
        if (m_rdata !== 8'h55) begin
            n_mis++;
            $display("FAIL rbw_new: rdata=%02h required 55", m_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic rdy;
        pulse_start(rdy);
        send_byte(8'h04); send_byte(8'h01);
        s_valid = 1'b1;
        s_data  = 8'h02;
        rst_n   = 1'b0;
        #2;
        n_cmp++;
        if ({s_ready, fetch_data, prog_len, cpu_run, busy, load_err, err_code} !== 19'd0) begin
            n_mis++;
            $display("FAIL reset_mid: outputs=%0h required 0", {s_ready, fetch_data, prog_len, cpu_run, busy, load_err, err_code});
        end
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_mid_idle: busy=%0b rdy=%0b required 0 0", busy, s_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_checksum();
        test_timeout();
        test_abort();
        test_random_gaps();
        test_rbw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
